cpu_run_ctrl: RTL
=================

# cpu_run_ctrl

Run/pause/single-step controller for the 6502 core on the DE0-Nano target. Sits between the board keys and `cpu_core`: it generates the CPU reset pulse (power-on and on request) and the CPU clock-enable. The clock-enable is either a free-running divided strobe in RUN, or exactly one strobe per debounced step-key press in PAUSE. All key inputs are raw, asynchronous and active-low; the block synchronizes and debounces them internally.

## Interface
- `RESET_CYCLES`, 255: length in clocks of the CPU reset hold; range 1..65535.
- `DEBOUNCE_CYCLES`, 20000: clocks a synchronized key level must stay stable before it is accepted; range 1..2^20.
- `CE_DIV`, 1: `cpu_ce` period in RUN, in clocks; 1 means asserted every cycle; range 1..2^16.
- `BOOT_RUN`, 1: state entered after reset hold; 1 = RUN, 0 = PAUSE.

Ports:
- `clk` in 1: single system clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `key_run_n` in 1: raw run/pause toggle key, active-low, asynchronous.
- `key_step_n` in 1: raw single-step key, active-low, asynchronous.
- `key_rst_n` in 1: raw CPU-reset request key, active-low, asynchronous.
- `cpu_reset` out 1: reset to `cpu_core`, active-high.
- `cpu_ce` out 1: clock-enable strobe to `cpu_core`.
- `running` out 1: high while in RUN (LED indicator).
- `state` out 2: current state; 0 = RESET_HOLD, 1 = RUN, 2 = PAUSE, 3 = STEP.

## Operation
- **Debouncer, one per key, identical:**
  - Two-flop synchronizer `s1` → `s2`.
  - Debounced level `db` and counter `cnt`.
  - If `s2 == db`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `db <= s2`, `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
  - Press event `ev` is a registered 1-cycle pulse, set on the same edge that `db` goes 1→0.
  - Release transitions generate no event.
  - Reset values: `s1 = s2 = db = 1`, `cnt = 0`, `ev = 0`.
- **FSM, registered `state`:**
  - RESET_HOLD:
    - `hold_cnt` increments each clock.
    - At the edge where `hold_cnt == RESET_CYCLES-1`, go to RUN if `BOOT_RUN`, else PAUSE.
    - `hold_cnt` is cleared whenever the state is not RESET_HOLD.
  - RUN:
    - `run_ev` → PAUSE.
    - `step_ev` is ignored.
  - PAUSE:
    - `run_ev` → RUN.
    - Otherwise `step_ev` → STEP.
  - STEP: always → PAUSE after one cycle.
  - From any state, `rst_ev` → RESET_HOLD. It takes priority over all other events.
  - Events arriving in RESET_HOLD or STEP, other than `rst_ev`, are discarded (not queued).
- **Outputs, decoded from registered state and counters:**
  - `cpu_reset = (state == RESET_HOLD)`.
  - `running = (state == RUN)`.
  - `cpu_ce = (state == RUN && ce_cnt == CE_DIV-1) || (state == STEP)`.
  - `ce_cnt` is held at 0 outside RUN.
  - In RUN, `ce_cnt` increments and wraps from CE_DIV-1 to 0.
  - `cpu_ce` is never high while `cpu_reset` is high.
- **`reset` asserted:**
  - All registers take their reset values on the next edge: state RESET_HOLD, `hold_cnt = 0`, `ce_cnt = 0`.
  - Resulting outputs: `cpu_reset = 1`, `cpu_ce = 0`, `running = 0`, `state = 0`.
  - `reset` mid-STEP or mid-RUN aborts immediately; no further `cpu_ce`.

## Timing
- Reset hold: after `reset` deasserts, `cpu_reset` is high for exactly RESET_CYCLES clocks; the state changes on the RESET_CYCLES-th edge.
- Key latency: call the first edge that samples a key low "edge 0".
  - `s2` goes low at edge 1.
  - `db` and `ev` update at edge DEBOUNCE_CYCLES+1.
  - The FSM changes state at edge DEBOUNCE_CYCLES+2.
- Bounce rejection: any key glitch shorter than DEBOUNCE_CYCLES clocks at `s2` restarts `cnt` and yields no event.
- Held keys: one event per press; no auto-repeat while the key is held.
- RUN strobe: counting the first clock in RUN as RUN cycle 1, `cpu_ce` is high in RUN cycles CE_DIV, 2·CE_DIV, ….
  - CE_DIV = 1 gives `cpu_ce` continuously high in RUN.
  - Leaving RUN drops `cpu_ce` on the same edge.
- STEP: `cpu_ce` is high for exactly one clock per step event.
  - PAUSE → STEP → PAUSE, with the FSM back in PAUSE two edges after `step_ev`.

## Test plan
- **Boot** (RESET_CYCLES = 8, DEBOUNCE_CYCLES = 4, CE_DIV = 3, BOOT_RUN = 1): release `reset` → `cpu_reset` high for 8 clocks, then `state = 1`, `running = 1`, `cpu_ce` high in RUN cycles 3, 6, 9; `cpu_ce = 0` throughout the hold.
- **Run/pause toggle:** hold `key_run_n` low for 12 clocks in RUN → `state = 2` at edge 6 after first low sample, `cpu_ce` stays 0. Release, then press again → `state = 1`, `ce_cnt` restarted, first `cpu_ce` 3 clocks later.
- **Bounce:** in RUN, drive `key_run_n` low 3 clocks, high 1, low 3, high → no state change; `state` remains 1.
- **Single step:** in PAUSE, press `key_step_n` twice (each held ≥ 6 clocks) → exactly two 1-clock `cpu_ce` pulses, `state` sequence 2→3→2 each time. The same press in RUN → no state change and an unchanged `cpu_ce` pattern.
- **Priority and reset request** (BOOT_RUN = 0): press `key_run_n` and `key_rst_n` so their events fire in the same cycle while in PAUSE → `state = 0`, `cpu_reset` high for 8 clocks, then `state = 2`; the run event is lost.
- **Synchronous reset mid-operation:** assert `reset` for 1 clock during STEP and, separately, during RUN with CE_DIV = 1 → on the next edge `state = 0`, `cpu_reset = 1`, `cpu_ce = 0`; pending debouncer counts are cleared, so a key held across `reset` needs a full DEBOUNCE_CYCLES+2 again.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run/pause/single-step controller for the 6502 core.
// Debounces the board keys and drives cpu_reset / cpu_ce.
module cpu_run_ctrl #(
  parameter int unsigned RESET_CYCLES    = 255,
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned CE_DIV          = 1,
  parameter bit          BOOT_RUN        = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_run_n,
  input  logic       key_step_n,
  input  logic       key_rst_n,
  output logic       cpu_reset,
  output logic       cpu_ce,
  output logic       running,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_STEP  = 2'd3
  } state_e;

  localparam int KRUN  = 0;
  localparam int KSTEP = 1;
  localparam int KRST  = 2;

  localparam logic [19:0] DB_MAX   = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] HOLD_MAX = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] CE_MAX   = 16'(CE_DIV - 1);

  logic [2:0] key_n;
  logic [2:0] s1_q, s1_d;
  logic [2:0] s2_q, s2_d;
  logic [2:0] db_q, db_d;
  logic [2:0] ev_q, ev_d;
  logic [2:0][19:0] cnt_q, cnt_d;

  state_e      state_q, state_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic [15:0] ce_cnt_q, ce_cnt_d;

  assign key_n = {key_rst_n, key_step_n, key_run_n};

  // Press event fires only on the accepted 1->0 transition of db.
  always_comb begin
    s1_d  = key_n;
    s2_d  = s1_q;
    db_d  = db_q;
    ev_d  = '0;
    cnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_MAX) begin
          db_d[i] = s2_q[i];
          ev_d[i] = db_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 20'd1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_MAX)
          state_d = BOOT_RUN ? ST_RUN : ST_PAUSE;
      end
      ST_RUN: begin
        if (ev_q[KRUN]) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (ev_q[KRUN])       state_d = ST_RUN;
        else if (ev_q[KSTEP]) state_d = ST_STEP;
      end
      ST_STEP: state_d = ST_PAUSE;
    endcase
    if (ev_q[KRST]) state_d = ST_HOLD;

    hold_cnt_d = '0;
    if (state_q == ST_HOLD && state_d == ST_HOLD
        && !ev_q[KRST])
      hold_cnt_d = hold_cnt_q + 16'd1;

    // ce_cnt restarts on every entry into RUN.
    ce_cnt_d = '0;
    if (state_q == ST_RUN && state_d == ST_RUN
        && ce_cnt_q != CE_MAX)
      ce_cnt_d = ce_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= '1;
      s2_q       <= '1;
      db_q       <= '1;
      ev_q       <= '0;
      cnt_q      <= '0;
      state_q    <= ST_HOLD;
      hold_cnt_q <= '0;
      ce_cnt_q   <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      db_q       <= db_d;
      ev_q       <= ev_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      ce_cnt_q   <= ce_cnt_d;
    end
  end

  assign state     = state_q;
  assign cpu_reset = (state_q == ST_HOLD);
  assign running   = (state_q == ST_RUN);
  assign cpu_ce    = (state_q == ST_RUN && ce_cnt_q == CE_MAX)
                   || (state_q == ST_STEP);

endmodule
